csi_clk_lane_mon: RTL and testbench

//  Frequency/activity monitor for the CSI byte clock distributed by the multi-region clock buffer tree.
//  - Runs in the system clock domain.
//  - Input is a toggle flop (byte_tgl) driven from the buffered byte-clock domain.
//  - Counts toggles per fixed window and qualifies the rate against a [MIN_CNT, MAX_CNT] band.
//  - Asserts locked for the downstream lane aligner / deserializer reset logic.

---
 rtl/csi_clk_lane_mon.sv | 181 ++++++++++++++++++
 tb/tb_csi_clk_lane_mon.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/csi_clk_lane_mon.sv
// csi_clk_lane_mon: measures the CSI byte-clock toggle rate per window in the clk domain and qualifies lock.
// Optional stuck-clock detector is built when CSI_CLK_MON_STUCK_EN is defined.
module csi_clk_lane_mon #(
  parameter int WIN_CYC   = 1024,
  parameter int CNT_W     = 16,
  parameter int MIN_CNT   = 200,
  parameter int MAX_CNT   = 300,
  parameter int LOCK_WINS = 4,
  parameter int LOSS_WINS = 2,
  parameter int STUCK_CYC = 64
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic             byte_tgl,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_vld,
  output logic             locked,
  output logic             lost_pls,
  output logic [1:0]       state
);

  localparam int               WIN_W     = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(MAX_CNT);
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_WINS - 1);
  localparam logic [3:0]       LOSS_LAST = 4'(LOSS_WINS - 1);
  localparam bit PARAM_OK = (WIN_CYC >= 16) && (LOCK_WINS >= 1) && (LOCK_WINS <= 15) &&
                            (LOSS_WINS >= 1) && (LOSS_WINS <= 15) && (STUCK_CYC >= 1) &&
                            (MIN_CNT <= MAX_CNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  logic             sync1_q, sync2_q, sync3_q;
  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
  logic             freq_vld_q, freq_vld_d;
  logic             lost_pls_q, lost_pls_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [3:0]       bad_cnt_q, bad_cnt_d;
  logic             run_en, edge_det, win_end, win_good, stuck_hit;
  logic [CNT_W-1:0] win_total;

  // A misconfigured instance stays idle rather than reporting a bogus lock.
  assign run_en    = en && PARAM_OK;
  assign edge_det  = sync2_q ^ sync3_q;
  assign win_end   = (state_q != ST_IDLE) && (win_cnt_q == WIN_LAST);
  assign win_total = (edge_det && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
  assign win_good  = (win_total >= MIN_V) && (win_total <= MAX_V) && (win_total != CNT_MAX);

`ifdef CSI_CLK_MON_STUCK_EN
  localparam int               STK_W    = $clog2(STUCK_CYC + 1);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYC - 1);

  logic [STK_W-1:0] stuck_cnt_q, stuck_cnt_d;

  assign stuck_hit = (state_q != ST_IDLE) && !edge_det && (stuck_cnt_q == STK_LAST);

  always_comb begin
    stuck_cnt_d = stuck_cnt_q + STK_W'(1);
    if (!run_en || (state_q == ST_IDLE) || edge_det || stuck_hit) begin
      stuck_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stuck_cnt_q <= '0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
    end
  end
`else
  assign stuck_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    freq_cnt_d = freq_cnt_q;
    freq_vld_d = 1'b0;
    lost_pls_d = 1'b0;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (!run_en) begin
      state_d    = ST_IDLE;
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_ACQ;
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (stuck_hit) begin
      // Abandon the current window outright; it never produces a freq_vld.
      state_d    = ST_ACQ;
      lost_pls_d = (state_q == ST_LOCK);
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (win_end) begin
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      freq_cnt_d = win_total;
      freq_vld_d = 1'b1;
      if (state_q == ST_ACQ) begin
        if (!win_good) begin
          good_cnt_d = '0;
        end else if (good_cnt_q == LOCK_LAST) begin
          state_d    = ST_LOCK;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end else begin
          good_cnt_d = good_cnt_q + 4'd1;
        end
      end else begin
        if (win_good) begin
          bad_cnt_d = '0;
        end else if (bad_cnt_q == LOSS_LAST) begin
          state_d    = ST_ACQ;
          lost_pls_d = 1'b1;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end else begin
          bad_cnt_d = bad_cnt_q + 4'd1;
        end
      end
    end else begin
      win_cnt_d  = win_cnt_q + WIN_W'(1);
      edge_cnt_d = win_total;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      state_q    <= ST_IDLE;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      freq_cnt_q <= '0;
      freq_vld_q <= 1'b0;
      lost_pls_q <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      sync1_q    <= byte_tgl;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      freq_cnt_q <= freq_cnt_d;
      freq_vld_q <= freq_vld_d;
      lost_pls_q <= lost_pls_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign freq_cnt = freq_cnt_q;
  assign freq_vld = freq_vld_q;
  assign locked   = (state_q == ST_LOCK);
  assign lost_pls = lost_pls_q;
  assign state    = state_q;

endmodule

// File: tb/tb_csi_clk_lane_mon.sv
// tb_csi_clk_lane_mon: directed bench for csi_clk_lane_mon at default parameters.
// Inputs are driven and outputs sampled on the falling clk edge.
module tb_csi_clk_lane_mon;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        en;
  logic        byte_tgl;
  logic [15:0] freq_cnt;
  logic        freq_vld;
  logic        locked;
  logic        lost_pls;
  logic [1:0]  state;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          tgl_period = 4;

  csi_clk_lane_mon dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .en       (en),
    .byte_tgl (byte_tgl),
    .freq_cnt (freq_cnt),
    .freq_vld (freq_vld),
    .locked   (locked),
    .lost_pls (lost_pls),
    .state    (state)
  );

  always #5 clk = ~clk;

  // byte_tgl flips every tgl_period clk cycles; 0 freezes it.
  initial begin : toggler
    int ph;
    ph = 0;
    byte_tgl = 1'b0;
    forever begin
      @(negedge clk);
      if (tgl_period > 0) begin
        ph++;
        if (ph >= tgl_period) begin
          ph = 0;
          byte_tgl = ~byte_tgl;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("  ok %s = %0d", tag, obs);
    end
  endtask

  task automatic wait_vld(input int max_cyc, output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    while (!got && (cyc < max_cyc)) begin
      @(negedge clk);
      cyc++;
      if (freq_vld) got = 1'b1;
    end
  endtask

  task automatic wait_lock(input int max_cyc, output bit got);
    int cyc;
    cyc = 0;
    while (!locked && (cyc < max_cyc)) begin
      @(negedge clk);
      cyc++;
    end
    got = locked;
  endtask

  initial begin : stim
    int cyc;
    int nv;
    bit got;
    bit seen;

    // Reset held with en high and byte_tgl running.
    arst_n = 1'b0;
    en     = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_freq_cnt", freq_cnt, 0);
    chk("rst_freq_vld", freq_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lost_pls", lost_pls, 0);
    chk("rst_state", state, 0);

    // Acquisition at 4-clk toggle period: 256 edges per 1024-cycle window.
    arst_n = 1'b1;
    wait_vld(2000, cyc, got);
    chk("acq1_vld_lat", cyc, 1025);
    chk("acq1_cnt_band", (freq_cnt >= 255) && (freq_cnt <= 257), 1);
    chk("acq1_locked", locked, 0);
    chk("acq1_state", state, 1);
    for (int w = 2; w <= 4; w++) begin
      wait_vld(1100, cyc, got);
      chk("acq_vld_gap", cyc, 1024);
      chk("acq_cnt", freq_cnt, 256);
      chk("acq_locked", locked, (w == 4));
    end
    chk("lock_state", state, 2);

    // Rate halves: two bad windows then loss of lock.
    tgl_period = 8;
    wait_vld(1100, cyc, got);
    chk("slow1_vld_gap", cyc, 1024);
    chk("slow1_cnt_band", (freq_cnt >= 120) && (freq_cnt <= 136), 1);
    chk("slow1_locked", locked, 1);
    chk("slow1_lost", lost_pls, 0);
    wait_vld(1100, cyc, got);
    chk("slow2_cnt", freq_cnt, 128);
    chk("slow2_lost", lost_pls, 1);
    chk("slow2_locked", locked, 0);
    chk("slow2_state", state, 1);
    @(negedge clk);
    chk("lost_one_cycle", lost_pls, 0);

    // Relock, then drop en mid-window.
    tgl_period = 4;
    wait_lock(8 * 1024, got);
    chk("relock1", got, 1);
    repeat (500) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("dis_state", state, 0);
    chk("dis_locked", locked, 0);
    chk("dis_lost", lost_pls, 0);
    chk("dis_vld", freq_vld, 0);
    chk("dis_cnt_held", freq_cnt, 256);
    seen = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      if (freq_vld || lost_pls || (state != 2'd0)) seen = 1'b1;
    end
    chk("dis_quiet", seen, 0);
    chk("dis_cnt_held2", freq_cnt, 256);

    // Re-enable: fresh window, lock on the 4th window.
    en = 1'b1;
    wait_vld(2000, cyc, got);
    chk("reen_vld_lat", cyc, 1025);
    chk("reen_cnt", freq_cnt, 256);
    nv = 1;
    while (!locked && (nv < 6)) begin
      wait_vld(1100, cyc, got);
      nv++;
    end
    chk("reen_lock_win", nv, 4);

    // Freeze byte_tgl while locked.
    tgl_period = 0;
`ifdef CSI_CLK_MON_STUCK_EN
    cyc  = 0;
    seen = 1'b0;
    while (!lost_pls && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
      if (freq_vld) seen = 1'b1;
    end
    chk("stuck_lost_seen", lost_pls, 1);
    chk("stuck_lost_in_time", (cyc <= 67), 1);
    chk("stuck_no_vld", seen, 0);
    chk("stuck_locked", locked, 0);
    chk("stuck_state", state, 1);
`else
    wait_vld(1100, cyc, got);
    chk("frz1_cnt_low", (freq_cnt <= 2), 1);
    chk("frz1_lost", lost_pls, 0);
    chk("frz1_locked", locked, 1);
    wait_vld(1100, cyc, got);
    chk("frz2_vld_gap", cyc, 1024);
    chk("frz2_cnt", freq_cnt, 0);
    chk("frz2_lost", lost_pls, 1);
    chk("frz2_locked", locked, 0);
    chk("frz2_state", state, 1);
`endif

    // Relock, then pulse the asynchronous reset mid-window.
    tgl_period = 4;
    wait_lock(8 * 1024, got);
    chk("relock2", got, 1);
    repeat (300) @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_locked", locked, 0);
    chk("arst_freq_cnt", freq_cnt, 0);
    chk("arst_vld", freq_vld, 0);
    chk("arst_lost", lost_pls, 0);
    @(negedge clk);
    arst_n = 1'b1;
    wait_vld(2000, cyc, got);
    chk("arst_vld_lat", cyc, 1025);
    chk("arst_cnt_band", (freq_cnt >= 255) && (freq_cnt <= 257), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
